sme_feeder: RTL
===============

# sme_feeder

Front-end stage for the string-matching engine (SME). It accepts a tagged byte stream from the host over a valid/ready handshake and buffers each record complete. It then replays the records to the SME as contiguous `isstring`/`ispattern` bursts, one character per cycle, and holds the next record until the SME pulses `valid` for the previous pattern. It also enforces the record-sequence and length rules, so the SME only ever sees legal input.

## Interface
- `STR_MAX`, 32: max characters per string record.
- `PAT_MAX`, 8: max characters per pattern record, including `^` and `$`.
- `FIFO_DEPTH`, 64: character buffer entries; power of two, ≥ STR_MAX+PAT_MAX.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk` in 1: the single clock.
  - `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host character valid.
- `in_ready` out 1: feeder accepts a character. Equals `!fifo_full`; 1 after reset.
- `in_data` in 8: ASCII character.
- `in_kind` in 1: 0 = string character, 1 = pattern character. Must be constant within a record.
- `in_last` in 1: last character of the current record.
- `chardata` out 8: character to the SME; 0 when not emitting.
- `isstring` out 1: string burst active.
- `ispattern` out 1: pattern burst active.
- `sme_valid` in 1: SME result-valid pulse.
- `err` out 1: sticky protocol/length error; cleared only by reset.
- `busy` out 1: FSM not in IDLE, or `records != 0`.

## Operation
**Input filter.** A character is accepted when `in_valid && in_ready`. The filter tracks `last_kind` (none/string/pattern) and `rec_len`.
- **Pattern with no prior string.** A pattern record before any string record since reset is dropped whole. Set `err`.
- **String after string.** A string record that directly follows a string record is dropped whole. Set `err`.
- **Over-length record.** Characters beyond STR_MAX (string) or PAT_MAX (pattern) are dropped. Set `err`. The `in_last` character is always written, replacing the last kept slot if the record is over-long, so the record is still closed.
- **Handshake on drops.** Dropped characters are still handshaken (`in_ready` is not lowered).
- **FIFO entry.** Kept characters are written to the FIFO as `{kind, last, data}` (10 bits).

**Record counter.** `records` counts complete records in the FIFO.
- +1 when a last-flagged entry is written; −1 when a last-flagged entry is popped.
- Both in the same cycle: unchanged.

**FSM** (FIFO is show-ahead):
- **IDLE**
  - Head kind = string and `records ≥ 2` → EMIT_STR.
  - Head kind = pattern and `records ≥ 1` → EMIT_PAT.
  - Otherwise stay.
- **EMIT_STR:** `isstring=1`, `chardata=head.data`, pop every cycle. Popping `head.last` → EMIT_PAT.
- **EMIT_PAT:** `ispattern=1`, pop every cycle. Popping `head.last` → WAIT_RES.
- **WAIT_RES:** outputs 0. `sme_valid` → IDLE.

**Other rules.**
- A pattern following IDLE reuses the string the SME already holds.
- `sme_valid` outside WAIT_RES is ignored.

## Timing
- **Reset values:** FSM = IDLE, FIFO empty, `records=0`, `last_kind=none`, `err=0`, `chardata=0`, `isstring=0`, `ispattern=0`, `busy=0`, `in_ready=1`.
- **Reset mid-burst:** outputs drop to 0 asynchronously and all buffered records are discarded. The SME reset is derived from `reset_n` at top level.
- **Latency:** last character of a record written at edge t → `records` updated at t → IDLE decides in cycle t+1 → first character on `chardata` in cycle t+2.
- **Burst shape:** the string burst of length S is immediately followed, with no gap, by the pattern burst of length P. The pattern bit rises in the cycle after the last string character.
- **Result gap:** at least one cycle of `isstring=ispattern=0` after the `sme_valid` cycle before the next burst.
- **Concurrency:** FIFO full with a simultaneous pop: `in_ready` follows registered `full` (no same-cycle pass-through).

## Structure
- **Package `sme_pkg`:** the `chardata` width, `KIND_STR`/`KIND_PAT`, the FSM state enum, and the ASCII constants `^`=8'd94, `$`=8'd36, `.`=8'd46, space=8'd32 (shared with the SME).
- **Sub-module `sme_sync_fifo`:** parameterized width/depth, show-ahead, with `full`/`empty`. Pointers are one bit wider than the address and wrap modulo depth.
- **Top:** the feeder holds the filter, record counter and FSM.

## Test plan
- **String then pattern:** string "ab cd" (5 chars) then pattern "cd" → `isstring` high for 5 cycles, `ispattern` high for 2 cycles immediately after; idle until `sme_valid`.
- **Pattern reuse:** second pattern "^ab" queued behind the first → emitted only after `sme_valid`, in a burst of 3, with no preceding string burst.
- **Over-length pattern:** 10-character pattern → 8 characters emitted, the last being the `in_last` character; `err=1`.
- **Illegal sequences:** a pattern before any string, and two strings back-to-back → both offending records absent from the output; `err=1`; later legal records unaffected.
- **Backpressure:** 64 characters pushed with the SME never returning `sme_valid` → `in_ready=0` at full; no characters lost after the FIFO drains.
- **Reset mid-burst:** `reset_n` low during EMIT_STR → outputs 0 immediately; after release, `busy=0`, `in_ready=1`, no residual burst.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared types and constants for the string-matching engine front end.
//   CHAR_W        character width on chardata / in_data
//   KIND_STR/PAT  record kind encoding
//   ST_*          feeder FSM state encoding
//   LK_*          last-accepted-record kind tracked by the input filter
//   ASCII_*       special characters understood by the SME
//   char_entry_t  buffered character {kind, last, data}
package sme_pkg;

    localparam int unsigned CHAR_W = 8;

    localparam logic KIND_STR = 1'b0;
    localparam logic KIND_PAT = 1'b1;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_EMIT_STR = 2'd1;
    localparam logic [ST_W-1:0] ST_EMIT_PAT = 2'd2;
    localparam logic [ST_W-1:0] ST_WAIT_RES = 2'd3;

    localparam logic [1:0] LK_NONE = 2'd0;
    localparam logic [1:0] LK_STR  = 2'd1;
    localparam logic [1:0] LK_PAT  = 2'd2;

    localparam logic [CHAR_W-1:0] ASCII_CARET  = 8'd94;
    localparam logic [CHAR_W-1:0] ASCII_DOLLAR = 8'd36;
    localparam logic [CHAR_W-1:0] ASCII_DOT    = 8'd46;
    localparam logic [CHAR_W-1:0] ASCII_SPACE  = 8'd32;

    typedef struct packed {
        logic              kind;
        logic              last;
        logic [CHAR_W-1:0] data;
    } char_entry_t;

    localparam int unsigned ENTRY_W = $bits(char_entry_t);

endpackage

// File: rtl/sme_sync_fifo.sv
// sme_sync_fifo: single-clock show-ahead FIFO.
//   clk, reset_n     clock, async active-low reset (empties the FIFO)
//   wr_en, wr_data   write request and payload
//   wr_replace       with wr_en: overwrite the most recently written slot instead of appending
//   rd_en            pop the head entry
//   rd_data          head entry (valid whenever !empty)
//   full, empty      status from the registered pointers
module sme_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             wr_replace,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr;
    logic             do_push;
    logic             do_store;
    logic             do_pop;

    // Replace needs no free slot: it rewrites an entry that is already counted.
    assign do_push  = wr_en && !wr_replace && !full;
    assign do_store = wr_en && (wr_replace || !full);
    assign do_pop   = rd_en && !empty;
    assign wr_addr  = wr_replace ? AW'(wr_ptr[AW-1:0] - AW'(1)) : wr_ptr[AW-1:0];

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array (no reset; only read behind valid pointers).
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: buffers host records and replays them to the SME as
// string/pattern bursts, one character per cycle.
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready                 host handshake
//   in_data, in_kind, in_last         character, 0=string 1=pattern, record end
//   chardata, isstring, ispattern     burst outputs to the SME
//   sme_valid                         SME result pulse, releases the next record
//   err                               sticky sequence/length error
//   busy                              FSM active or complete records buffered
module sme_feeder
    import sme_pkg::*;
#(
    parameter int unsigned STR_MAX    = 32,
    parameter int unsigned PAT_MAX    = 8,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_kind,
    input  logic              in_last,
    output logic [CHAR_W-1:0] chardata,
    output logic              isstring,
    output logic              ispattern,
    input  logic              sme_valid,
    output logic              err,
    output logic              busy
);

    localparam int unsigned REC_MAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int unsigned LEN_W   = $clog2(REC_MAX + 1);
    localparam int unsigned REC_W   = $clog2(FIFO_DEPTH + 1);

    // Filter state
    logic [1:0]       last_kind;
    logic             rec_active;
    logic             rec_drop;
    logic [LEN_W-1:0] rec_len;

    // Buffer / scheduler state
    logic [REC_W-1:0] records;
    logic [ST_W-1:0]  state;

    logic             fifo_full;
    logic             fifo_empty;
    char_entry_t      head;
    char_entry_t      wr_entry;

    logic             accept_c;
    logic             illegal_c;
    logic             drop_rec_c;
    logic [LEN_W-1:0] rec_max_c;
    logic             room_c;
    logic             wr_en_c;
    logic             overlen_c;

    logic [ST_W-1:0]  next_state_c;
    logic             pop_c;
    logic             emit_str_c;
    logic             emit_pat_c;
    logic [REC_W-1:0] records_next_c;

    assign in_ready = !fifo_full;
    assign wr_entry = '{kind: in_kind, last: in_last, data: in_data};

    // Input filter decisions; drop status is fixed by the first character of a record.
    assign accept_c   = in_valid && in_ready;
    assign illegal_c  = ((in_kind == KIND_PAT) && (last_kind == LK_NONE)) ||
                        ((in_kind == KIND_STR) && (last_kind == LK_STR));
    assign drop_rec_c = rec_active ? rec_drop : illegal_c;
    assign rec_max_c  = (in_kind == KIND_PAT) ? LEN_W'(PAT_MAX) : LEN_W'(STR_MAX);
    assign room_c     = (rec_len < rec_max_c);
    // The closing character always lands, overwriting the last kept slot if full-length.
    assign wr_en_c    = accept_c && !drop_rec_c && (room_c || in_last);
    assign overlen_c  = accept_c && !drop_rec_c && !room_c;

    sme_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_c),
        .wr_replace (!room_c),
        .wr_data    (wr_entry),
        .rd_en      (pop_c),
        .rd_data    (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Filter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_kind  <= LK_NONE;
            rec_active <= 1'b0;
            rec_drop   <= 1'b0;
            rec_len    <= '0;
            err        <= 1'b0;
        end else if (accept_c) begin
            if (drop_rec_c || overlen_c) begin
                err <= 1'b1;
            end
            if (in_last) begin
                rec_active <= 1'b0;
                rec_drop   <= 1'b0;
                rec_len    <= '0;
                if (!drop_rec_c) begin
                    last_kind <= (in_kind == KIND_PAT) ? LK_PAT : LK_STR;
                end
            end else begin
                rec_active <= 1'b1;
                rec_drop   <= drop_rec_c;
                if (!drop_rec_c && room_c) begin
                    rec_len <= rec_len + LEN_W'(1);
                end
            end
        end
    end

    // Complete-record count: written closers in, popped closers out.
    always_comb begin
        records_next_c = records;
        if (wr_en_c && in_last && !(pop_c && head.last)) begin
            records_next_c = records + REC_W'(1);
        end else if (!(wr_en_c && in_last) && pop_c && head.last) begin
            records_next_c = records - REC_W'(1);
        end
    end

    // Scheduler next-state; a string only starts once its pattern is also complete.
    always_comb begin
        next_state_c = state;
        pop_c        = 1'b0;
        emit_str_c   = 1'b0;
        emit_pat_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if ((head.kind == KIND_STR) && (records >= REC_W'(2))) begin
                        pop_c        = 1'b1;
                        emit_str_c   = 1'b1;
                        next_state_c = head.last ? ST_EMIT_PAT : ST_EMIT_STR;
                    end else if ((head.kind == KIND_PAT) && (records >= REC_W'(1))) begin
                        pop_c        = 1'b1;
                        emit_pat_c   = 1'b1;
                        next_state_c = head.last ? ST_WAIT_RES : ST_EMIT_PAT;
                    end
                end
            end
            ST_EMIT_STR: begin
                pop_c      = 1'b1;
                emit_str_c = 1'b1;
                if (head.last) begin
                    next_state_c = ST_EMIT_PAT;
                end
            end
            ST_EMIT_PAT: begin
                pop_c      = 1'b1;
                emit_pat_c = 1'b1;
                if (head.last) begin
                    next_state_c = ST_WAIT_RES;
                end
            end
            default: begin
                if (sme_valid) begin
                    next_state_c = ST_IDLE;
                end
            end
        endcase
    end

    // State, record count and registered SME-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            records   <= '0;
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state_c;
            records   <= records_next_c;
            chardata  <= (emit_str_c || emit_pat_c) ? head.data : '0;
            isstring  <= emit_str_c;
            ispattern <= emit_pat_c;
            busy      <= (next_state_c != ST_IDLE) || (records_next_c != '0);
        end
    end

endmodule
